// File: rtl/addsub16_seq_ctrl.sv
// rtl/addsub16_seq_ctrl.sv - sequential SLICE-bit add/sub with valid/ready handshakes (optional ADDSUB_OVF_EN)
module addsub16_seq_ctrl #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_sub,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
`ifdef ADDSUB_OVF_EN
    output logic             ovf,
`endif
    output logic             zero
);

    localparam int N  = WIDTH / SLICE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b_inv;
    logic             carry;
    logic [IW-1:0]    idx;
    logic [SLICE:0]   sum;
    logic [WIDTH-1:0] res_next;
    logic             last;

    assign req_ready = (state == IDLE);
    assign res_valid = (state == DONE);
    assign last      = (idx == IW'(N - 1));

    // One slice of the ripple: current slice of a plus inverted b plus running carry.
    always_comb begin
        sum      = {1'b0, a[int'(idx)*SLICE +: SLICE]}
                 + {1'b0, b_inv[int'(idx)*SLICE +: SLICE]}
                 + {{SLICE{1'b0}}, carry};
        res_next = result;
        res_next[int'(idx)*SLICE +: SLICE] = sum[SLICE-1:0];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: accept, walk N slices, then wait for the consumer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = CALC;
            CALC:    if (last)      state_next = DONE;
            DONE:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, slice-by-slice result build and flag registration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a         <= '0;
            b_inv     <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
`ifdef ADDSUB_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        a     <= op_a;
                        b_inv <= op_b ^ {WIDTH{op_sub}};
                        carry <= op_sub;
                        idx   <= '0;
                    end
                end
                CALC: begin
                    result <= res_next;
                    carry  <= sum[SLICE];
                    if (last) begin
                        carry_out <= sum[SLICE];
                        zero      <= (res_next == '0);
`ifdef ADDSUB_OVF_EN
                        // Same-sign operands giving a different-sign result is
                        // equivalent to carry-into-MSB xor carry-out-of-MSB.
                        ovf <= (a[WIDTH-1] == b_inv[WIDTH-1])
                            && (res_next[WIDTH-1] != a[WIDTH-1]);
`endif
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
